// File: rtl/iter_shift_unit.sv
// Iterative shift unit: logical left/right, arithmetic right and rotate left,
// one bit position per clock, with a one-cycle done pulse on completion.
module iter_shift_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [WIDTH-1:0]   result_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned LW = $clog2(WIDTH);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [1:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CW-1:0]    eff_cnt;
  logic [WIDTH-1:0] shifted;
  logic             accept;

  // Effective shift count: rotate wraps modulo WIDTH, the others saturate at WIDTH
  always_comb begin
    eff_cnt = '0;
    if (op_i == OP_ROL) begin
      eff_cnt = CW'(b_i[LW-1:0]);
    end else if (b_i >= WIDTH'(WIDTH)) begin
      eff_cnt = CW'(WIDTH);
    end else begin
      eff_cnt = CW'(b_i);
    end
  end

  // One-position shift of the working value in the captured direction
  always_comb begin
    shifted = result_q;
    case (op_q)
      OP_SLL:  shifted = {result_q[WIDTH-2:0], 1'b0};
      OP_SRL:  shifted = {1'b0, result_q[WIDTH-1:1]};
      OP_SRA:  shifted = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
      OP_ROL:  shifted = {result_q[WIDTH-2:0], result_q[WIDTH-1]};
      default: shifted = result_q;
    endcase
  end

  // Next-state, datapath and output decode
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) accept = 1'b1;
      end
      S_SHIFT: begin
        result_d = shifted;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (start_i) accept = 1'b1;
        else         state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A start in DONE is taken exactly like one in IDLE, giving back-to-back operation
    if (accept) begin
      result_d = a_i;
      op_d     = op_i;
      cnt_d    = eff_cnt;
      state_d  = (eff_cnt == '0) ? S_DONE : S_SHIFT;
    end

    busy_d = (state_d == S_SHIFT);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      op_q     <= OP_SLL;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule
